// File: rtl/controller_tdma.sv
// Per-node protocol controller: registered packet-field decoder plus a TDMA slot-gated transmitter
// with CCA retry/backoff and relay. Define CTRL_LFSR_BACKOFF_EN for pseudo-random backoff.
module controller_tdma #(
    parameter int WORD_WIDTH  = 16,
    parameter int NUM_SLOTS   = 16,
    parameter int SLOT_CYCLES = 64,
    parameter int MAX_HOPS    = 8,
    parameter int MAX_RETRY   = 3,
    parameter int BACKOFF_W   = 4
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         pkt_valid,
    input  logic [2:0]                   fPacketType,
    input  logic [WORD_WIDTH-1:0]        fHopsFromCH,
    input  logic [WORD_WIDTH-1:0]        fChosenCH,
    input  logic [WORD_WIDTH-1:0]        fTimeslot,
    input  logic [WORD_WIDTH-1:0]        destinationID,
    input  logic                         channel_clear,
    input  logic [WORD_WIDTH-1:0]        myTimeslot,
    input  logic [WORD_WIDTH-1:0]        myNodeID,
    input  logic                         role,
    input  logic                         iHaveData,
    input  logic [WORD_WIDTH-1:0]        chosenCH,
    output logic                         en_KCH,
    output logic                         en_MNI,
    output logic                         en_QTU_FMB,
    output logic                         en_neighborTable,
    output logic                         en_reward,
    output logic                         iAmDestination,
    output logic                         okToSend,
    output logic                         tx_drop,
    output logic                         tx_pending,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
    output logic [1:0]                   tx_state_dbg
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int CYC_W  = $clog2(SLOT_CYCLES);
    localparam int RTY_W  = $clog2(MAX_RETRY + 2);
    localparam int BO_W   = BACKOFF_W + RTY_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_CCA       = 2'd2,
        ST_BACKOFF   = 2'd3
    } tx_state_t;

    tx_state_t         state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [SLOT_W-1:0] slot_q, slot_d, slot_nxt;
    logic [RTY_W-1:0]  retry_q, retry_d, retry_inc;
    logic [BO_W-1:0]   bo_q, bo_d, bo_len;
    logic relay_q, relay_d, mask_q, mask_d, ok_q, ok_d, drop_q, drop_d;
    logic en_kch_q, en_kch_d, en_mni_q, en_mni_d, en_qtu_q, en_qtu_d;
    logic en_nt_q, en_nt_d, en_rw_q, en_rw_d, dest_q, dest_d;
    logic cyc_last, own_now, own_next, pend, relay_set, relay_clr, mask_set, data_me;
    logic unused_fields;

    // fTimeslot is parsed upstream but carries nothing this controller acts on.
    assign unused_fields = ^fTimeslot;

`ifdef CTRL_LFSR_BACKOFF_EN
    logic [15:0] lfsr_q, lfsr_d, lfsr_seed;
    always_comb begin
        lfsr_seed = 16'hACE1 ^ 16'(myNodeID);
        if (lfsr_seed == 16'h0000) lfsr_seed = 16'h0001;
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        bo_len = BO_W'(lfsr_q[BACKOFF_W-1:0]) + BO_W'(1);
    end
`else
    always_comb bo_len = BO_W'(retry_inc) << 2;
`endif

    always_comb begin
        // Slot timebase and own-slot detection; an out-of-range myTimeslot never matches.
        cyc_last  = (cyc_q == CYC_W'(SLOT_CYCLES - 1));
        slot_nxt  = (slot_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_q + SLOT_W'(1);
        cyc_d     = cyc_last ? '0 : cyc_q + CYC_W'(1);
        slot_d    = cyc_last ? slot_nxt : slot_q;
        own_now   = (WORD_WIDTH'(slot_q) == myTimeslot);
        own_next  = (WORD_WIDTH'(slot_nxt) == myTimeslot);
        retry_inc = retry_q + RTY_W'(1);

        data_me   = pkt_valid && (fPacketType == 3'b101) && (destinationID == myNodeID);
        en_nt_d   = pkt_valid && ((fPacketType == 3'b000) ||
                                  ((fPacketType == 3'b011) && (fChosenCH == chosenCH)));
        en_rw_d   = pkt_valid && ((fPacketType == 3'b000) || (fPacketType == 3'b110));
        en_mni_d  = pkt_valid && ((fPacketType == 3'b001) ||
                                  ((fPacketType == 3'b100) && (destinationID == myNodeID)));
        en_kch_d  = pkt_valid && (((fPacketType == 3'b010) &&
                                   (fHopsFromCH < WORD_WIDTH'(MAX_HOPS))) ||
                                  (fPacketType == 3'b110));
        en_qtu_d  = data_me;
        dest_d    = data_me;
        relay_set = data_me && !role;

        // A local frame that was dropped stays masked until iHaveData deasserts.
        pend      = (iHaveData && !mask_q) || relay_q;

        state_d   = state_q;
        retry_d   = retry_q;
        bo_d      = bo_q;
        ok_d      = 1'b0;
        drop_d    = 1'b0;
        relay_clr = 1'b0;
        mask_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend) state_d = ST_WAIT_SLOT;
            end
            ST_WAIT_SLOT: begin
                if (!pend) begin
                    state_d = ST_IDLE;
                end else if ((cyc_last && own_next) ||
                             (own_now && (cyc_q < CYC_W'(SLOT_CYCLES - 2)))) begin
                    state_d = ST_CCA;
                end
            end
            ST_CCA: begin
                if (cyc_last) begin
                    state_d = ST_WAIT_SLOT;
                end else if (channel_clear) begin
                    ok_d      = 1'b1;
                    relay_clr = relay_q;
                    retry_d   = '0;
                    state_d   = ST_IDLE;
                end else if (retry_q == RTY_W'(MAX_RETRY)) begin
                    drop_d    = 1'b1;
                    relay_clr = relay_q;
                    mask_set  = !relay_q;
                    retry_d   = '0;
                    state_d   = ST_IDLE;
                end else begin
                    retry_d = retry_inc;
                    bo_d    = bo_len;
                    state_d = ST_BACKOFF;
                end
            end
            ST_BACKOFF: begin
                if (cyc_last) begin
                    state_d = ST_WAIT_SLOT;
                end else if (bo_q <= BO_W'(1)) begin
                    state_d = ST_CCA;
                end else begin
                    bo_d = bo_q - BO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        relay_d = (relay_q && !relay_clr) || relay_set;
        mask_d  = mask_set || (mask_q && iHaveData);
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q  <= ST_IDLE;
            cyc_q    <= '0;
            slot_q   <= '0;
            retry_q  <= '0;
            bo_q     <= '0;
            relay_q  <= 1'b0;
            mask_q   <= 1'b0;
            ok_q     <= 1'b0;
            drop_q   <= 1'b0;
            en_kch_q <= 1'b0;
            en_mni_q <= 1'b0;
            en_qtu_q <= 1'b0;
            en_nt_q  <= 1'b0;
            en_rw_q  <= 1'b0;
            dest_q   <= 1'b0;
`ifdef CTRL_LFSR_BACKOFF_EN
            lfsr_q   <= lfsr_seed;
`endif
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            slot_q   <= slot_d;
            retry_q  <= retry_d;
            bo_q     <= bo_d;
            relay_q  <= relay_d;
            mask_q   <= mask_d;
            ok_q     <= ok_d;
            drop_q   <= drop_d;
            en_kch_q <= en_kch_d;
            en_mni_q <= en_mni_d;
            en_qtu_q <= en_qtu_d;
            en_nt_q  <= en_nt_d;
            en_rw_q  <= en_rw_d;
            dest_q   <= dest_d;
`ifdef CTRL_LFSR_BACKOFF_EN
            lfsr_q   <= lfsr_d;
`endif
        end
    end

    assign en_KCH           = en_kch_q;
    assign en_MNI           = en_mni_q;
    assign en_QTU_FMB       = en_qtu_q;
    assign en_neighborTable = en_nt_q;
    assign en_reward        = en_rw_q;
    assign iAmDestination   = dest_q;
    assign okToSend         = ok_q;
    assign tx_drop          = drop_q;
    assign tx_pending       = iHaveData | relay_q;
    assign slot_idx         = slot_q;
    assign tx_state_dbg     = state_q;
endmodule

// File: doc/controller_tdma.md
# controller_tdma

Second-generation per-node protocol controller for the EER-RL sensor node. It decodes received packet fields into single-cycle enable pulses for knownCH, myNodeInfo, the Q-table/FMB unit, the neighbor table and the reward unit. It also owns the transmit side: a TDMA frame/slot counter, gating by the node's own timeslot, channel-clear checking with bounded retry/backoff, and relaying of data packets toward the cluster head. It sits between the packet parser/radio front end and the per-node storage blocks.

## Interface
- WORD_WIDTH, 16, width of ID/hop/timeslot fields
- NUM_SLOTS, 16, timeslots per TDMA frame (≥2)
- SLOT_CYCLES, 64, clock cycles per timeslot (≥8)
- MAX_HOPS, 8, INV packets with fHopsFromCH ≥ MAX_HOPS are ignored
- MAX_RETRY, 3, channel-busy retries before a frame is dropped
- BACKOFF_W, 4, backoff counter width

Ports:
- clk  in  1  clock; all logic on rising edge
- nrst  in  1  reset, synchronous, active-high (1 = reset)
- pkt_valid  in  1  packet fields valid this cycle
- fPacketType  in  3  000 HB, 001 CHE, 010 INV, 011 MR, 100 CHT, 101 DATA, 110 SOS, 111 none
- fHopsFromCH, fChosenCH, fTimeslot, destinationID  in  WORD_WIDTH  parsed packet fields
- channel_clear  in  1  medium idle
- myTimeslot, myNodeID  in  WORD_WIDTH  from myNodeInfo
- role  in  1  0 member, 1 cluster head
- iHaveData  in  1  level; local data awaiting transmission
- chosenCH  in  WORD_WIDTH  from knownCH
- en_KCH, en_MNI, en_QTU_FMB, en_neighborTable, en_reward  out  1  one-cycle enables
- iAmDestination  out  1  one-cycle pulse: DATA addressed to this node
- okToSend  out  1  one-cycle grant to radio
- tx_drop  out  1  one-cycle pulse: frame abandoned after retries
- tx_pending  out  1  level: a local or relay frame is queued
- slot_idx  out  clog2(NUM_SLOTS)  current slot

## Operation
Decoder (independent of TX FSM), on pkt_valid:
- HB: en_neighborTable, en_reward
- CHE: en_MNI
- INV: en_KCH if fHopsFromCH < MAX_HOPS
- MR: en_neighborTable if fChosenCH == chosenCH
- CHT: en_MNI if destinationID == myNodeID
- DATA to myNodeID: iAmDestination, en_QTU_FMB; role==0 also sets relay_pend
- SOS: en_KCH, en_reward
- 111 or pkt_valid=0: nothing
- A pending frame exists when iHaveData or relay_pend is set; tx_pending = iHaveData | relay_pend.

TDMA counter: cyc_cnt 0..SLOT_CYCLES-1, then slot_idx increments and wraps NUM_SLOTS-1→0. Own slot when slot_idx == myTimeslot; a myTimeslot ≥ NUM_SLOTS (including all-ones) means unassigned, so the node never transmits.

TX FSM:
- IDLE→WAIT_SLOT when tx_pending.
- WAIT_SLOT→CCA on entering own slot, or immediately if already in it with cyc_cnt < SLOT_CYCLES-2.
- CCA: if channel_clear, okToSend pulses; relay_pend clears if set (relay served first), else the local frame is served; retry_cnt←0; →IDLE.
- CCA, busy: if retry_cnt == MAX_RETRY, tx_drop pulses, the served source clears (relay_pend cleared; iHaveData is external, so it is masked until it deasserts), retry_cnt←0, →IDLE. Otherwise retry_cnt++ and →BACKOFF.
- BACKOFF: counts down, then →CCA.
- A slot end during CCA/BACKOFF aborts to WAIT_SLOT; retry_cnt is kept.
- A new DATA packet while relay_pend is already set is OR-ed in (single-entry, no queue).

## Timing
- Reset: all outputs 0, slot_idx 0, cyc_cnt 0, FSM IDLE, retry_cnt 0, relay_pend 0.
- Decoder enables are registered: they appear the cycle after pkt_valid and last exactly one cycle.
- okToSend appears the cycle after channel_clear is sampled high in CCA.
- CCA lasts one cycle.
- Reset mid-transmit: FSM returns to IDLE and the pending relay is lost.
- Decode and okToSend may pulse in the same cycle.

## Configuration
- CTRL_LFSR_BACKOFF_EN defined: backoff = 1 + lfsr[BACKOFF_W-1:0] cycles, using a 16-bit Fibonacci LFSR (taps 16,14,13,11). The LFSR loads 16'hACE1 ^ myNodeID during reset and is forced nonzero.
- Not defined: deterministic backoff = (retry_cnt) × 4 cycles, with retry_cnt taken after its increment.

## Test plan
- Decode sweep: pulse pkt_valid with types 000–111, myNodeID=12, chosenCH=23, fChosenCH=23/35, destinationID=12/3 → exactly the listed enables one cycle later; none for a mismatch or for 111.
- INV hops: fHopsFromCH=1 → en_KCH; fHopsFromCH=8 → no pulse.
- Slot gating: myTimeslot=2, iHaveData=1, channel_clear=1 → okToSend at slot_idx=2, cycle 1 of that slot; myTimeslot=16'hffff → never.
- Retry/drop: channel_clear=0 throughout own slot, MAX_RETRY=3 → 3 backoffs, then tx_drop once and no okToSend.
- Relay: DATA to node 12 with role=0 → iAmDestination, relay_pend set, okToSend in own slot, tx_pending falls; with role=1 → no relay.
- Slot abort: channel busy across the slot boundary → WAIT_SLOT, retry_cnt preserved, success in the next frame.
